// File: rtl/ofifo_drain_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ofifo_drain_ctrl_pkg
// Description : Shared constants and state encoding for the ofifo drain
//               controller and any core controller that sequences it.
// Revision    : 1.0 - initial release
// ============================================================================
package ofifo_drain_ctrl_pkg;

    // Default widths: psum SRAM address and drained-row count.
    localparam int c_DEF_ADDR_W = 11;
    localparam int c_DEF_CNT_W  = 12;
    localparam int c_STATE_W    = 3;

    // Drain sequencer states.
    typedef enum logic [c_STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_GAP   = 3'd2,
        S_FLUSH = 3'd3,
        S_FIN   = 3'd4
    } state_t;

endpackage : ofifo_drain_ctrl_pkg
`default_nettype wire

// File: rtl/drain_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : drain_addr_gen
// Description : psum SRAM write-address generator. Loads the base address at
//               job start, then produces base + rows_written (mod 2^ADDR_W)
//               one cycle after each ofifo read, aligned with the write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module drain_addr_gen #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_written;
    logic [ADDR_W-1:0] r_addr;

    // Base/row-counter load on start; each read registers the next address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base    <= '0;
            r_written <= '0;
            r_addr    <= '0;
        end else if (load) begin
            r_base    <= base_addr;
            r_written <= '0;
        end else if (inc) begin
            // Address arithmetic is ADDR_W wide, so it wraps silently.
            r_addr    <= r_base + ADDR_W'(r_written);
            r_written <= r_written + 1'b1;
        end
    end

    assign addr = r_addr;

endmodule : drain_addr_gen
`default_nettype wire

// File: rtl/ofifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ofifo_drain_ctrl
// Description : Drains the column-parallel output FIFO after a PE-array pass.
//               Pops one full row every other cycle while all columns are
//               non-empty, issues the matching psum SRAM write one cycle
//               later, and pulses done after the programmed row count or an
//               abort.
// Revision    : 1.0 - initial release
// ============================================================================
module ofifo_drain_ctrl
    import ofifo_drain_ctrl_pkg::*;
#(
    parameter int ADDR_W = c_DEF_ADDR_W,
    parameter int CNT_W  = c_DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_rows,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              ofifo_valid,
    input  logic              ofifo_full,
    output logic              ofifo_rd,
    output logic              sram_wr,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              busy,
    output logic              done,
    output logic              ovf_seen
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_num_rows;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] w_issued_inc;
    logic             r_sram_wr;
    logic             r_ovf_seen;
    logic             w_start_ok;
    logic             w_rd;
    logic             w_busy;

    assign w_start_ok   = (r_state == S_IDLE) && start;
    assign w_issued_inc = r_issued + 1'b1;
    assign w_busy       = (r_state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and read-request decode.
    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_rows != '0) ? S_POP : S_FIN;
                end
            end
            S_POP: begin
                if (abort) begin
                    // No write can be in flight here: reads only leave POP.
                    w_state_nxt = S_FIN;
                end else if (r_issued >= r_num_rows) begin
                    w_state_nxt = S_FLUSH;
                end else if (ofifo_valid) begin
                    w_rd        = 1'b1;
                    w_state_nxt = (w_issued_inc == r_num_rows) ? S_FLUSH : S_GAP;
                end
            end
            S_GAP: begin
                // Empty flags lag a read by two cycles; this slot prevents an
                // over-read. The write for the previous read retires here.
                w_state_nxt = abort ? S_FIN : S_POP;
            end
            S_FLUSH: begin
                // The final read's write strobe is on the bus this cycle and
                // no further read is issued, so the job can finish next.
                w_state_nxt = S_FIN;
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Job parameters, read counter, write strobe pipeline and overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_rows <= '0;
            r_issued   <= '0;
            r_sram_wr  <= 1'b0;
            r_ovf_seen <= 1'b0;
        end else begin
            r_sram_wr <= w_rd;
            if (w_start_ok) begin
                r_num_rows <= num_rows;
                r_issued   <= '0;
            end else if (w_rd) begin
                r_issued <= w_issued_inc;
            end
            if (w_start_ok) begin
                r_ovf_seen <= 1'b0;
            end else if (w_busy && ofifo_full) begin
                r_ovf_seen <= 1'b1;
            end
        end
    end

    drain_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_drain_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (w_start_ok),
        .base_addr (base_addr),
        .inc       (w_rd),
        .addr      (sram_addr)
    );

    assign ofifo_rd = w_rd;
    assign sram_wr  = r_sram_wr;
    assign busy     = w_busy;
    assign done     = (r_state == S_FIN);
    assign ovf_seen = r_ovf_seen;

endmodule : ofifo_drain_ctrl
`default_nettype wire

// File: tb/tb_ofifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ofifo_drain_ctrl
// Description : Scoreboard bench for ofifo_drain_ctrl. Stimulus pushes the
//               expected rd/wr/done events and status snapshots; a monitor
//               on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ofifo_drain_ctrl;

    localparam int c_ADDR_W = 11;
    localparam int c_CNT_W  = 12;

    logic                clk;
    logic                reset;
    logic                start;
    logic                abort;
    logic [c_CNT_W-1:0]  num_rows;
    logic [c_ADDR_W-1:0] base_addr;
    logic                ofifo_valid;
    logic                ofifo_full;
    logic                ofifo_rd;
    logic                sram_wr;
    logic [c_ADDR_W-1:0] sram_addr;
    logic                busy;
    logic                done;
    logic                ovf_seen;

    ofifo_drain_ctrl #(
        .ADDR_W (c_ADDR_W),
        .CNT_W  (c_CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .num_rows    (num_rows),
        .base_addr   (base_addr),
        .ofifo_valid (ofifo_valid),
        .ofifo_full  (ofifo_full),
        .ofifo_rd    (ofifo_rd),
        .sram_wr     (sram_wr),
        .sram_addr   (sram_addr),
        .busy        (busy),
        .done        (done),
        .ovf_seen    (ovf_seen)
    );

    // Event kinds: 0 = ofifo_rd, 1 = sram_wr, 2 = done
    typedef struct {
        int                  kind;
        int                  cyc;
        logic [c_ADDR_W-1:0] addr;
    } ev_t;

    // Status selectors: 0 busy, 1 ovf_seen, 2 all outputs, 3 pending events
    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] val;
        string       nm;
    } st_t;

    ev_t ev_q[$];
    st_t st_q[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] obs(int sel);
        case (sel)
            0:       return {15'd0, busy};
            1:       return {15'd0, ovf_seen};
            2:       return {ofifo_rd, sram_wr, busy, done, ovf_seen, sram_addr};
            default: return 16'(ev_q.size());
        endcase
    endfunction

    task automatic check_ev(int kind, logic [c_ADDR_W-1:0] addr);
        ev_t e;
        total++;
        if (ev_q.size() > 0 && ev_q[0].cyc == cyc && ev_q[0].kind == kind) begin
            e = ev_q.pop_front();
            if (e.addr != addr) begin
                bad++;
                $display("FAIL ev_addr kind=%0d cyc=%0d got=%h exp=%h", kind, cyc, addr, e.addr);
            end
        end else begin
            bad++;
            $display("FAIL ev_unexpected kind=%0d cyc=%0d addr=%h exp_next_kind=%0d exp_next_cyc=%0d",
                     kind, cyc, addr, (ev_q.size() > 0) ? ev_q[0].kind : -1,
                     (ev_q.size() > 0) ? ev_q[0].cyc : -1);
        end
    endtask

    // Monitor: flag missed events, match observed events, then status snapshots.
    always @(negedge clk) begin
        ev_t e;
        st_t s;
        logic [15:0] got;
        while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
            e = ev_q.pop_front();
            total++;
            bad++;
            $display("FAIL ev_missing kind=%0d got=none exp_cyc=%0d exp_addr=%h", e.kind, e.cyc, e.addr);
        end
        if (ofifo_rd) check_ev(0, '0);
        if (sram_wr)  check_ev(1, sram_addr);
        if (done)     check_ev(2, '0);
        while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
            s   = st_q.pop_front();
            got = obs(s.sel);
            total++;
            if (s.cyc != cyc || got != s.val) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%h exp=%h (exp_cyc=%0d)", s.nm, cyc, got, s.val, s.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(int c);
        while (cyc < c) tick();
    endtask

    task automatic push_ev(int kind, int c, logic [c_ADDR_W-1:0] a);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.addr = a;
        ev_q.push_back(e);
    endtask

    task automatic push_st(int c, int sel, logic [15:0] v, string nm);
        st_t s;
        s.cyc = c;
        s.sel = sel;
        s.val = v;
        s.nm  = nm;
        st_q.push_back(s);
    endtask

    // Issue a one-cycle start; returns the cycle in which start was driven.
    task automatic go(int n, logic [c_ADDR_W-1:0] b, output int s);
        s         = cyc;
        start     = 1'b1;
        num_rows  = c_CNT_W'(n);
        base_addr = b;
        tick();
        start     = 1'b0;
    endtask

    // Expected events for an uninterrupted job with ofifo_valid held high.
    task automatic push_full_job(int s, int n, logic [c_ADDR_W-1:0] b);
        for (int i = 0; i < n; i++) begin
            push_ev(0, s + 1 + 2 * i, '0);
            push_ev(1, s + 2 + 2 * i, c_ADDR_W'(b + c_ADDR_W'(i)));
        end
        push_ev(2, s + 2 * n + 1, '0);
    endtask

    initial begin
        int s;
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        num_rows    = '0;
        base_addr   = '0;
        ofifo_valid = 1'b0;
        ofifo_full  = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        push_st(cyc, 2, 16'h0000, "reset_outputs");
        tick();

        // Four rows, valid always high: one row every two cycles.
        ofifo_valid = 1'b1;
        go(4, 11'h010, s);
        push_full_job(s, 4, 11'h010);
        push_st(s + 9, 0, 16'h0001, "busy_in_fin");
        push_st(s + 10, 0, 16'h0000, "busy_after_done");
        push_st(s + 11, 3, 16'h0000, "job4_drained");
        wait_to(s + 12);

        // Three rows, valid pattern 1,0,0 repeating from the first POP cycle.
        ofifo_valid = 1'b0;
        go(3, 11'h100, s);
        push_ev(0, s + 1, '0);
        push_ev(1, s + 2, 11'h100);
        push_ev(0, s + 4, '0);
        push_ev(1, s + 5, 11'h101);
        push_ev(0, s + 7, '0);
        push_ev(1, s + 8, 11'h102);
        push_ev(2, s + 9, '0);
        push_st(s + 11, 3, 16'h0000, "toggle_drained");
        for (int k = 1; k <= 11; k++) begin
            ofifo_valid = ((k - 1) % 3 == 0);
            tick();
        end
        ofifo_valid = 1'b0;

        // ofifo_full while idle must not set the sticky flag.
        ofifo_full = 1'b1;
        push_st(cyc + 1, 1, 16'h0000, "ovf_idle_ignored");
        tick();
        ofifo_full = 1'b0;

        // Zero rows: straight to FIN, no reads or writes.
        go(0, 11'h123, s);
        push_ev(2, s + 1, '0);
        push_st(s + 1, 0, 16'h0001, "zero_busy_fin");
        push_st(s + 3, 3, 16'h0000, "zero_drained");
        wait_to(s + 4);

        // Address wrap at the top of the SRAM.
        ofifo_valid = 1'b1;
        go(4, 11'h7FE, s);
        push_full_job(s, 4, 11'h7FE);
        push_st(s + 11, 3, 16'h0000, "wrap_drained");
        wait_to(s + 12);

        // Abort in the GAP after the second read.
        go(8, 11'h020, s);
        push_ev(0, s + 1, '0);
        push_ev(1, s + 2, 11'h020);
        push_ev(0, s + 3, '0);
        push_ev(1, s + 4, 11'h021);
        push_ev(2, s + 5, '0);
        push_st(s + 5, 0, 16'h0001, "abort_busy_fin");
        push_st(s + 6, 0, 16'h0000, "abort_busy_idle");
        push_st(s + 8, 3, 16'h0000, "abort_drained");
        wait_to(s + 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_to(s + 9);

        // Reset in the cycle of a read: the following write is suppressed.
        go(4, 11'h030, s);
        push_ev(0, s + 1, '0);
        reset = 1'b1;
        push_st(s + 2, 2, 16'h0000, "reset_mid_outputs");
        tick();
        reset = 1'b0;
        push_st(s + 4, 3, 16'h0000, "reset_mid_drained");
        wait_to(s + 5);

        // Normal job after the mid-job reset.
        go(2, 11'h040, s);
        push_full_job(s, 2, 11'h040);
        push_st(s + 7, 3, 16'h0000, "post_reset_drained");
        wait_to(s + 8);

        // Overflow flag, ignored start while busy, and flag clear on next start.
        ofifo_valid = 1'b0;
        go(4, 11'h050, s);
        push_ev(0, s + 4, '0);
        push_ev(1, s + 5, 11'h050);
        push_ev(0, s + 6, '0);
        push_ev(1, s + 7, 11'h051);
        push_ev(0, s + 8, '0);
        push_ev(1, s + 9, 11'h052);
        push_ev(0, s + 10, '0);
        push_ev(1, s + 11, 11'h053);
        push_ev(2, s + 12, '0);
        push_st(s + 3, 1, 16'h0001, "ovf_set");
        push_st(s + 12, 1, 16'h0001, "ovf_hold_done");
        push_st(s + 14, 1, 16'h0001, "ovf_sticky_idle");
        push_st(s + 14, 3, 16'h0000, "ovf_job_drained");
        wait_to(s + 2);
        ofifo_full = 1'b1;
        tick();
        ofifo_full = 1'b0;
        wait_to(s + 4);
        ofifo_valid = 1'b1;
        wait_to(s + 5);
        start     = 1'b1;
        num_rows  = 12'd1;
        base_addr = 11'h3FF;
        tick();
        start = 1'b0;
        wait_to(s + 15);

        go(0, 11'h000, s);
        push_ev(2, s + 1, '0);
        push_st(s + 1, 1, 16'h0000, "ovf_cleared_by_start");
        push_st(s + 3, 3, 16'h0000, "final_drained");
        wait_to(s + 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=cycle %0d exp=finish", cyc);
        $fatal(1, "bench timeout");
    end

endmodule : tb_ofifo_drain_ctrl
`default_nettype wire
